alu_dp_arbiter: RTL and testbench
=================================

# alu_dp_arbiter

Round-robin arbiter sharing the single ALU/register-file datapath between N control sequencers. Each requester presents its own 16-bit control word. The arbiter grants one owner at a time, forwards that owner's word to the datapath, and forces a zero word (no register write) on every cycle without a grant. It also inserts a one-cycle turnaround between owners and registers the datapath status flags for the current owner.

## Interface
- N, 4: number of requesters, 2..8
- MAX_HOLD, 16: maximum consecutive owner cycles before forced release (only with timeout compiled in), 2..255
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req  in  N  request, one bit per requester; must stay high until the transaction ends
- last  in  N  requester marks its final control-word cycle
- cw_in  in  16*N  control words; requester i occupies [16i+15:16i]; fields: [15:13] cnt_alu, [12:9] slc_mux_a, [8:5] slc_mux_b, [4:1] slc_reg, [0] w
- mayor, zero, neg  in  1 each  datapath status flags
- o_signal  out  16  control word to datapath
- gnt  out  N  one-hot grant, registered
- owner  out  clog2(N)  index of current/last owner, registered
- flags_q  out  3  registered {mayor, zero, neg}
- preempt  out  1  one-cycle pulse on forced release

## Operation
- States: IDLE, OWN, TURN.
- IDLE: gnt=0 and o_signal=0.
  - If req!=0, the requester at or after ptr+1 (mod N) wins. gnt/owner load at the next edge and the state becomes OWN.
- OWN: gnt[owner]=1 and o_signal = cw_in slice for owner (combinational pass-through).
  - Exit to TURN when the clock edge samples req[owner]&last[owner] (the last word is executed that cycle) or req[owner]=0.
  - When req[owner]=0, o_signal is forced to 0 in that same cycle.
- TURN: gnt=0 and o_signal=0 for exactly one cycle. ptr<=owner.
  - If req!=0 in TURN, arbitrate as in IDLE and go to OWN. Otherwise go to IDLE.
  - The previous owner is lowest priority.
- Round-robin: search order ptr+1, ptr+2, … ptr (wrapping mod N). ptr resets to N-1, so requester 0 wins first after reset.
- flags_q loads {mayor,zero,neg} on every OWN cycle where o_signal[15:13]!=0. It holds otherwise.
- owner holds its value through TURN and IDLE.
- Requests from non-owners during OWN are ignored until TURN; nothing is queued beyond the req level.
- last asserted by a non-owner is ignored.
- Reset mid-transaction: all outputs clear immediately. After release the state is IDLE and ptr=N-1.

## Timing
- Reset values: o_signal=0, gnt=0, owner=0, flags_q=0, preempt=0, state IDLE, ptr=N-1, hold count 0.
- Request-to-grant latency: 1 cycle from an IDLE sample; 1 cycle from a TURN sample.
- Minimum owner tenure: 1 cycle (req+last on the first OWN cycle).
- Back-to-back owners are separated by exactly one zero cycle (TURN).
- o_signal changes combinationally with cw_in only during OWN. Every other output is registered.
- Simultaneous req/last deassert and a new req from another requester: TURN, then grant the new requester.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter increments each OWN cycle and clears on entering OWN.
  - When the count reaches MAX_HOLD-1 and any other req bit is high, the state goes to TURN at that edge and preempt pulses 1 for the TURN cycle.
  - The preempted requester keeps req high and re-competes at lowest priority.
  - With no other requester pending, the owner is never preempted.
- ARB_TIMEOUT_EN undefined: no counter. preempt is tied 0. Tenure is unbounded.

## Test plan
- Reset: rst=0 with req=4'b1111 -> all outputs 0. After rst=1, gnt=4'b0001 one cycle later and owner=0.
- Single transaction: req[2] held 3 cycles with cw_in[2]=16'h4C80 and last on cycle 3 -> o_signal=16'h4C80 for 3 cycles, then 16'h0000 in TURN, then IDLE.
- Round-robin: req=4'b1011 held with last pulsed each grant -> grant order 0,1,3,0 with one zero cycle between each.
- Flag capture: owner word 16'h8048 with neg=1, zero=0, mayor=1 -> flags_q=3'b101 next cycle. Owner word 16'h0240 with flags changed -> flags_q unchanged.
- Requester abort: req[owner] drops mid-transaction -> o_signal=0 that cycle, then TURN.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req[0] never asserts last and req[1] is high -> gnt[0] for 4 cycles, then preempt=1 with gnt=0, then gnt[1]. Without the macro, gnt[0] persists indefinitely.

Source files
------------

// File: rtl/alu_dp_arbiter.sv
// Round-robin arbiter sharing one ALU/register-file datapath between N control sequencers.
// Optional forced release after MAX_HOLD owner cycles: compile with ARB_TIMEOUT_EN.
module alu_dp_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 16,
    localparam int unsigned OwnerW  = $clog2(N)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N-1:0]      req_i,
    input  logic [N-1:0]      last_i,
    input  logic [16*N-1:0]   cw_in_i,
    input  logic              mayor_i,
    input  logic              zero_i,
    input  logic              neg_i,
    output logic [15:0]       o_signal_o,
    output logic [N-1:0]      gnt_o,
    output logic [OwnerW-1:0] owner_o,
    output logic [2:0]        flags_q_o,
    output logic              preempt_o
);

    typedef enum logic [1:0] {StIdle, StOwn, StTurn} state_e;

    state_e              state_q, state_d;
    logic [OwnerW-1:0]   ptr_q, ptr_d;
    logic [OwnerW-1:0]   owner_q, owner_d;
    logic [N-1:0]        gnt_q, gnt_d;
    logic [2:0]          flags_q, flags_d;
    logic                preempt_q, preempt_d;

    logic                own_req, own_last, timeout;
    logic                win_valid;
    logic [OwnerW-1:0]   win_idx;

    assign own_req  = req_i[owner_q];
    assign own_last = last_i[owner_q];

    // ptr_q already holds the previous owner in TURN, so it is naturally lowest priority.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= int'(N); i++) begin
            if (!win_valid && req_i[(int'(ptr_q) + i) % int'(N)]) begin
                win_valid = 1'b1;
                win_idx   = OwnerW'((int'(ptr_q) + i) % int'(N));
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;

    assign timeout = (hold_q >= 8'(MAX_HOLD - 1)) && |(req_i & ~gnt_q);

    always_comb begin
        hold_d = hold_q;
        if (state_q != StOwn) begin
            hold_d = '0;
        end else if (hold_q != 8'hff) begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ptr_q   <= OwnerW'(N - 1);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle, StTurn: begin
                state_d = win_valid ? StOwn : StIdle;
            end
            StOwn: begin
                if (!own_req || own_last || timeout) begin
                    state_d = StTurn;
                    ptr_d   = owner_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        o_signal_o = 16'h0000;
        owner_d    = owner_q;
        gnt_d      = '0;
        flags_d    = flags_q;
        preempt_d  = 1'b0;
        if (state_q == StOwn && own_req) begin
            o_signal_o = cw_in_i[16*owner_q +: 16];
        end
        if (state_q == StOwn && o_signal_o[15:13] != 3'd0) begin
            flags_d = {mayor_i, zero_i, neg_i};
        end
        if (state_q == StOwn) begin
            preempt_d = (state_d == StTurn) && timeout && own_req && !own_last;
            if (state_d == StOwn) begin
                gnt_d = gnt_q;
            end
        end else if (state_d == StOwn) begin
            owner_d = win_idx;
            gnt_d   = N'(1) << win_idx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q   <= '0;
            gnt_q     <= '0;
            flags_q   <= '0;
            preempt_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            gnt_q     <= gnt_d;
            flags_q   <= flags_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign owner_o   = owner_q;
    assign flags_q_o = flags_q;
    assign preempt_o = preempt_q;

endmodule

// File: tb/tb_alu_dp_arbiter.sv
// Self-checking bench for alu_dp_arbiter: cycle model plus directed literal checks.
// Timeout expectations follow ARB_TIMEOUT_EN when it is defined.
module tb_alu_dp_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit Tmo = 1'b1;
`else
    localparam bit Tmo = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    last = '0;
    logic [16*N-1:0] cw_in = '0;
    logic            mayor = 1'b0, zero = 1'b0, neg = 1'b0;
    logic [15:0]     o_signal;
    logic [N-1:0]    gnt;
    logic [1:0]      owner;
    logic [2:0]      flags_q;
    logic            preempt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_dp_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .last_i    (last),
        .cw_in_i   (cw_in),
        .mayor_i   (mayor),
        .zero_i    (zero),
        .neg_i     (neg),
        .o_signal_o(o_signal),
        .gnt_o     (gnt),
        .owner_o   (owner),
        .flags_q_o (flags_q),
        .preempt_o (preempt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_phase: 0 = nobody owns, 1 = owner active, 2 = gap cycle between owners
    int          m_phase, m_owner, m_ptr, m_hold;
    logic [2:0]  m_flags;
    logic        m_pre;

    function automatic int pick(input int p, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    logic [15:0]  m_word;
    logic [N-1:0] m_gnt;
    int           m_win;
    logic         m_others;
    assign m_word   = (m_phase == 1 && req[m_owner]) ? cw_in[16*m_owner +: 16] : 16'h0000;
    assign m_gnt    = (m_phase == 1) ? (N'(1) << m_owner) : '0;
    assign m_win    = pick(m_ptr, req);
    assign m_others = (req & ~(N'(1) << m_owner)) != '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_owner <= 0; m_ptr <= N - 1; m_hold <= 0;
            m_flags <= 3'b000; m_pre <= 1'b0;
        end else if (m_phase == 1) begin
            if (m_word[15:13] != 3'd0) m_flags <= {mayor, zero, neg};
            if (!req[m_owner] || last[m_owner]) begin
                m_phase <= 2; m_ptr <= m_owner; m_pre <= 1'b0;
            end else if (Tmo && m_hold >= MAX_HOLD - 1 && m_others) begin
                m_phase <= 2; m_ptr <= m_owner; m_pre <= 1'b1;
            end else begin
                m_hold <= m_hold + 1; m_pre <= 1'b0;
            end
        end else begin
            m_pre <= 1'b0;
            if (m_win >= 0) begin
                m_phase <= 1; m_owner <= m_win; m_hold <= 0;
            end else begin
                m_phase <= 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("model o_signal", 32'(o_signal), 32'(m_word));
        chk("model gnt",      32'(gnt),      32'(m_gnt));
        chk("model owner",    32'(owner),    32'(m_owner));
        chk("model flags_q",  32'(flags_q),  32'(m_flags));
        chk("model preempt",  32'(preempt),  32'(m_pre));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_mid();
        @(negedge clk);
        #1;
    endtask

    logic [N-1:0] rr_exp [8];
    logic [N-1:0] to_exp [6];

    initial begin
        cw_in[15:0]  = 16'h2003;
        cw_in[31:16] = 16'h6021;
        cw_in[47:32] = 16'h4C80;
        cw_in[63:48] = 16'hA0F5;

        // Reset with every requester pending
        req = 4'b1111;
        repeat (3) at_mid();
        chk("reset gnt", 32'(gnt), 32'h0);
        chk("reset o_signal", 32'(o_signal), 32'h0);
        chk("reset owner", 32'(owner), 32'h0);
        chk("reset flags", 32'(flags_q), 32'h0);
        chk("reset preempt", 32'(preempt), 32'h0);
        rst_n = 1'b1;
        tick();
        at_mid();
        chk("first grant", 32'(gnt), 32'b0001);
        chk("first owner", 32'(owner), 32'h0);
        chk("first word", 32'(o_signal), 32'h2003);

        // Abort: owner drops req mid-transaction
        tick();
        req = 4'b0000;
        at_mid();
        chk("abort o_signal", 32'(o_signal), 32'h0);
        chk("abort gnt", 32'(gnt), 32'b0001);
        tick();
        at_mid();
        chk("abort turn gnt", 32'(gnt), 32'h0);
        tick();

        // Single transaction on requester 2
        req = 4'b0100;
        tick();
        at_mid();
        chk("single c1", 32'(o_signal), 32'h4C80);
        tick();
        at_mid();
        chk("single c2", 32'(o_signal), 32'h4C80);
        tick();
        last = 4'b0100;
        at_mid();
        chk("single c3", 32'(o_signal), 32'h4C80);
        chk("single owner", 32'(owner), 32'h2);
        tick();
        req = 4'b0000; last = 4'b0000;
        at_mid();
        chk("single turn o", 32'(o_signal), 32'h0);
        chk("single turn gnt", 32'(gnt), 32'h0);
        chk("single owner hold", 32'(owner), 32'h2);
        tick();
        at_mid();
        chk("single idle gnt", 32'(gnt), 32'h0);

        // Round-robin from a fresh pointer
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 4'b1011; last = 4'b1011;
        rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        for (int k = 0; k < 8; k++) begin
            tick();
            at_mid();
            chk($sformatf("rr gnt[%0d]", k), 32'(gnt), 32'(rr_exp[k]));
        end
        tick();
        req = 4'b0000; last = 4'b0000;
        repeat (3) tick();

        // Flag capture on requester 1
        cw_in[31:16] = 16'h8048;
        mayor = 1'b1; zero = 1'b0; neg = 1'b1;
        req = 4'b0010;
        tick();
        at_mid();
        chk("flag word", 32'(o_signal), 32'h8048);
        tick();
        cw_in[31:16] = 16'h0240;
        mayor = 1'b0; zero = 1'b1; neg = 1'b0;
        at_mid();
        chk("flags load", 32'(flags_q), 32'b101);
        tick();
        last = 4'b0010;
        at_mid();
        chk("flags hold", 32'(flags_q), 32'b101);
        tick();
        req = 4'b0000; last = 4'b0000;
        at_mid();
        chk("flags turn", 32'(flags_q), 32'b101);
        repeat (2) tick();

        // Timeout: requester 0 never finishes while requester 1 waits
        req = 4'b0011;
        if (Tmo) to_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
        else     to_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        for (int k = 0; k < 6; k++) begin
            tick();
            at_mid();
            chk($sformatf("timeout gnt[%0d]", k), 32'(gnt), 32'(to_exp[k]));
            if (k == 4) chk("timeout preempt", 32'(preempt), 32'(Tmo));
        end
        tick();
        req = 4'b0000;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
